flag_window_stat: RTL and testbench

Downstream consumer of flag_counter's flag_count output. It counts rising edges of the flag over a fixed window of WIN_LEN clock cycles. At each window end it latches the count, with saturation, into a result register. The result is offered to the next stage over a valid/ready handshake. Sticky overrun reporting flags any result dropped because the consumer stalled.

---
 rtl/flag_stat_pkg.sv | 10 +
 rtl/flag_edge_det.sv | 26 ++
 rtl/flag_window_stat.sv | 123 ++++++++++++
 tb/tb_flag_window_stat.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_stat_pkg.sv
// Shared types for the flag window statistics block.
//   state_t : window FSM encoding (idle / running windows)
package flag_stat_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/flag_edge_det.sv
// Rising-edge detector for the incoming event flag.
//   clk_p   : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   flag_in : level event flag
//   rise_c  : combinational rising-edge pulse (flag_in & ~flag_d)
module flag_edge_det (
    input  logic clk_p,
    input  logic rst_n,
    input  logic flag_in,
    output logic rise_c
);

    logic flag_d;

    // Delayed flag; runs every cycle regardless of window state.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            flag_d <= 1'b0;
        end else begin
            flag_d <= flag_in;
        end
    end

    assign rise_c = flag_in & ~flag_d;

endmodule

// File: rtl/flag_window_stat.sv
// Counts rising edges of flag_in over fixed windows of WIN_LEN cycles and
// offers each window's saturating count over a valid/ready handshake.
//   clk_p     : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   enable    : run windows while high
//   clear     : synchronous clear of accumulator, window and result state
//   flag_in   : level event flag (rising edge = one event)
//   res_ready : consumer accepts result
//   res_valid : result available
//   res_count : edge count of the completed window
//   res_sat   : res_count reached its maximum in that window
//   overrun   : sticky, a completed window was dropped under backpressure
//   busy      : FSM is running windows
module flag_window_stat
    import flag_stat_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned WIN_W   = 10,
    parameter int unsigned WIN_LEN = 1000
) (
    input  logic             clk_p,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             flag_in,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [CNT_W-1:0] res_count,
    output logic             res_sat,
    output logic             overrun,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

    state_t           state;
    logic [CNT_W-1:0] acc;
    logic [WIN_W-1:0] win_cnt;
    logic             rise_c;
    logic [CNT_W-1:0] acc_next_c;
    logic             win_end_c;
    logic             load_c;

    flag_edge_det u_edge (
        .clk_p   (clk_p),
        .rst_n   (rst_n),
        .flag_in (flag_in),
        .rise_c  (rise_c)
    );

    // Saturating accumulate; also the window result on the last cycle.
    always_comb begin
        acc_next_c = acc;
        if (acc != CNT_MAX) begin
            acc_next_c = acc + CNT_W'(rise_c);
        end
    end

    assign win_end_c = (state == ST_RUN) && (win_cnt == WIN_LAST);
    // A finished window may load only into an empty or draining result slot.
    assign load_c    = win_end_c && (!res_valid || res_ready);

    // FSM, window counter, accumulator and result register.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            win_cnt   <= '0;
            res_valid <= 1'b0;
            res_count <= '0;
            res_sat   <= 1'b0;
            overrun   <= 1'b0;
        end else if (clear) begin
            state     <= enable ? ST_RUN : ST_IDLE;
            acc       <= '0;
            win_cnt   <= '0;
            res_valid <= 1'b0;
            res_count <= '0;
            res_sat   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (win_end_c) begin
                        // Window completes even if enable drops on this cycle.
                        acc     <= '0;
                        win_cnt <= '0;
                        if (load_c) begin
                            res_valid <= 1'b1;
                            res_count <= acc_next_c;
                            res_sat   <= (acc_next_c == CNT_MAX);
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (!enable) begin
                        // Partial window is discarded.
                        acc     <= '0;
                        win_cnt <= '0;
                    end else begin
                        acc     <= acc_next_c;
                        win_cnt <= win_cnt + WIN_W'(1);
                    end
                    if (!enable) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_flag_window_stat.sv
// Directed bench for flag_window_stat with WIN_LEN=10; a CNT_W=3 instance and
// a CNT_W=2 instance share all inputs.
module tb_flag_window_stat;

    logic       clk_p;
    logic       rst_n;
    logic       enable;
    logic       clear;
    logic       flag_in;
    logic       res_ready;

    logic       res_valid;
    logic [2:0] res_count;
    logic       res_sat;
    logic       overrun;
    logic       busy;

    logic       valid2;
    logic [1:0] count2;
    logic       sat2;
    logic       ovr2;
    logic       busy2;

    int n_chk;
    int n_fail;

    flag_window_stat #(.CNT_W(3), .WIN_W(10), .WIN_LEN(10)) dut (
        .clk_p     (clk_p),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear     (clear),
        .flag_in   (flag_in),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_count (res_count),
        .res_sat   (res_sat),
        .overrun   (overrun),
        .busy      (busy)
    );

    flag_window_stat #(.CNT_W(2), .WIN_W(10), .WIN_LEN(10)) dut2 (
        .clk_p     (clk_p),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear     (clear),
        .flag_in   (flag_in),
        .res_ready (res_ready),
        .res_valid (valid2),
        .res_count (count2),
        .res_sat   (sat2),
        .overrun   (ovr2),
        .busy      (busy2)
    );

    initial clk_p = 1'b0;
    always #5 clk_p = ~clk_p;

    typedef struct {
        logic [9:0] pat;   // bit i = flag_in on window cycle i
        int         exp3;
        int         sat3;
        int         exp2;
        int         sat2;
    } win_vec_t;

    win_vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    task automatic cyc(input logic en, input logic clr, input logic fl, input logic rdy);
        enable    = en;
        clear     = clr;
        flag_in   = fl;
        res_ready = rdy;
        tick();
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        enable    = 1'b0;
        clear     = 1'b0;
        flag_in   = 1'b0;
        res_ready = 1'b1;

        // Table: consecutive windows, enable=1, res_ready=1.
        vecs[0] = '{10'b1000010000, 2, 0, 2, 0};  // pulse every 5, incl. window end
        vecs[1] = '{10'b1000010000, 2, 0, 2, 0};
        vecs[2] = '{10'b0000000000, 0, 0, 0, 0};
        vecs[3] = '{10'b1111111111, 1, 0, 1, 0};  // held high: one event
        vecs[4] = '{10'b1111111111, 0, 0, 0, 0};
        vecs[5] = '{10'b1010101010, 5, 0, 3, 1};  // 5 edges, 2-bit saturates
        vecs[6] = '{10'b0101010101, 4, 0, 3, 1};
        vecs[7] = '{10'b0000010101, 3, 0, 3, 1};  // exactly reaches 2-bit max

        // Reset and idle.
        #3;
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_count", 32'(res_count), 0);
        chk("rst_busy", 32'(busy), 0);
        flag_in = 1'b1;
        tick();
        flag_in = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b0, 1'b0, 1'(i % 2), 1'b1);
            chk("idle_valid", 32'(res_valid), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_ovr", 32'(overrun), 0);
        end

        // Start running; windows begin on the first RUN cycle.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("start_busy", 32'(busy), 1);
        chk("start_valid", 32'(res_valid), 0);

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 10; i++) begin
                cyc(1'b1, 1'b0, vecs[v].pat[i], 1'b1);
                chk("win_valid", 32'(res_valid), (i == 9) ? 32'd1 : 32'd0);
            end
            chk("win_count", 32'(res_count), 32'(vecs[v].exp3));
            chk("win_sat", 32'(res_sat), 32'(vecs[v].sat3));
            chk("win_count2", 32'(count2), 32'(vecs[v].exp2));
            chk("win_sat2", 32'(sat2), 32'(vecs[v].sat2));
            chk("win_ovr", 32'(overrun), 0);
            chk("win_busy", 32'(busy), 1);
        end

        // Clear to idle.
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("clr_valid", 32'(res_valid), 0);
        chk("clr_busy", 32'(busy), 0);
        chk("clr_count", 32'(res_count), 0);

        // Backpressure: result held, second window dropped.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, (i == 4 || i == 9), 1'b0);
        end
        chk("bp_valid", 32'(res_valid), 1);
        chk("bp_count", 32'(res_count), 2);
        begin
            logic [9:0] pat_b;
            pat_b = 10'b0010100010;
            for (int i = 0; i < 10; i++) begin
                cyc(1'b1, 1'b0, pat_b[i], 1'b0);
                chk("bp_hold_valid", 32'(res_valid), 1);
                chk("bp_hold_count", 32'(res_count), 2);
                chk("bp_ovr", 32'(overrun), (i == 9) ? 32'd1 : 32'd0);
            end
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            chk("bp_stall_count", 32'(res_count), 2);
            chk("bp_stall_ovr", 32'(overrun), 1);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("bp_xfer_valid", 32'(res_valid), 0);
        chk("bp_xfer_ovr", 32'(overrun), 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("bp_clr_ovr", 32'(overrun), 0);
        chk("bp_clr_busy", 32'(busy), 1);

        // Load coinciding with transfer at window end.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, (i == 4 || i == 9), 1'b0);
        end
        chk("co_first_count", 32'(res_count), 2);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, (i == 1), (i == 9));
        end
        chk("co_valid", 32'(res_valid), 1);
        chk("co_count", 32'(res_count), 1);
        chk("co_ovr", 32'(overrun), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("co_drain_valid", 32'(res_valid), 0);

        // Enable drop mid-window discards the partial window.
        for (int i = 1; i < 6; i++) begin
            cyc(1'b1, 1'b0, (i % 2 == 1), 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("drop_busy", 32'(busy), 0);
        chk("drop_valid", 32'(res_valid), 0);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            chk("drop_idle_valid", 32'(res_valid), 0);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("reen_busy", 32'(busy), 1);
        // Enable falls on the window-end cycle: window still loads.
        for (int i = 0; i < 10; i++) begin
            cyc((i != 9), 1'b0, (i == 3), 1'b1);
        end
        chk("reen_valid", 32'(res_valid), 1);
        chk("reen_count", 32'(res_count), 1);
        chk("reen_count2", 32'(count2), 1);
        chk("reen_sat", 32'(res_sat), 0);
        chk("reen_busy_end", 32'(busy), 0);

        // Asynchronous reset mid-window with a pending result.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 13; i++) begin
            cyc(1'b1, 1'b0, (i == 4 || i == 9), 1'b0);
        end
        chk("pre_rst_valid", 32'(res_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(res_valid), 0);
        chk("arst_count", 32'(res_count), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ovr", 32'(overrun), 0);
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            chk("post_rst_valid", 32'(res_valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
